ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Parametrised multi-cycle RV32M/RV64M execute unit. It sits beside the EX-stage ALU and takes M-extension ops (opcode 0110011, funct7 0000001) after operand forwarding.
- Multiplies use a fixed-latency pipelined multiplier. Divides and remainders use an iterative restoring divider.
- A valid/ready handshake lets the pipeline hold IF/ID/EX while the unit is busy.

Parameters:
- XLEN, 32, operand and result width (32 or 64).
- MUL_STAGES, 2, cycles from accept to result valid for MUL* ops (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  kill any in-flight op (branch taken / trap).
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept; equals state==IDLE.
- in_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_rs1  in  XLEN  forwarded operand A.
- in_rs2  in  XLEN  forwarded operand B.
- in_rd  in  5  destination register tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer (EX/MEM register) accepts.
- out_result  out  XLEN  result.
- out_rd  out  5  tag returned with the result.
- busy  out  1  state != IDLE; drives the pipeline stall.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, out_valid=0, out_result=0, out_rd=0, busy=0, all counters=0. Reset mid-operation abandons the op; no result is produced.
- Accept: at a posedge with in_valid && in_ready && !flush, latch funct3, operands and rd. Move to MUL if funct3[2]=0, otherwise to DIV.
- Only one op is outstanding at a time. in_ready=0 in MUL, DIV and DONE.
- MUL state:
  - Counter runs from MUL_STAGES-1 down to 0. At 0, go to DONE with out_valid=1 exactly MUL_STAGES cycles after accept.
  - Form a 2*XLEN product with signedness per funct3: MULH s×s, MULHSU s×u, MULHU u×u, MUL low half.
  - MUL returns product[XLEN-1:0]; the other three return product[2XLEN-1:XLEN].
- DIV state, normal case:
  - Signed ops take absolute values.
  - Run one restoring step per cycle for XLEN cycles, then one sign-fix cycle.
  - out_valid is asserted XLEN+1 cycles after accept.
  - Quotient sign = sign(A) xor sign(B). Remainder sign = sign(A).
- DIV state, special cases (decided at accept, out_valid the next cycle):
  - Divisor 0: quotient = all ones; remainder = A.
  - Signed overflow (A = 1<<(XLEN-1), B = -1): quotient = A; remainder = 0.
  - The unsigned ops never hit the overflow case.
- DONE state:
  - out_valid=1; out_result and out_rd are stable.
  - Leave to IDLE on the first posedge with out_ready=1. out_valid drops the cycle after.
  - With out_ready=0, hold indefinitely with no change.
- Flush:
  - In any state, flush=1 at a posedge moves to IDLE and clears out_valid.
  - Flush has priority over accept and over an out handshake in the same cycle.
  - A flushed op never produces out_valid.
- Back-to-back: the earliest re-accept is the cycle after the DONE handshake, when in_ready=1 again.
- All arithmetic is modulo 2^XLEN. No X propagation on out_result while out_valid=0; it holds its last value.

Test Plan:
- MUL 7×-3 (0x00000007, 0xFFFFFFFD), MUL_STAGES=2, out_ready=1 -> out_valid 2 cycles after accept, out_result=0xFFFFFFEB, out_rd echoed, busy=1 for 3 cycles.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF.
- DIV -20/6 -> quotient 0xFFFFFFFD, out_valid at cycle 33. REM -20/6 -> 0xFFFFFFFE. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Special cases: DIV 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000. REM 0x80000000/-1 -> 0. Each has out_valid 1 cycle after accept.
- Backpressure and flush: hold out_ready=0 for 5 cycles after DONE -> out_valid and out_result held, in_ready=0. Assert flush at DIV cycle 10 -> IDLE next cycle, no out_valid, new accept succeeds.
- Reset: pull rst_n low during DIV cycle 20 -> next posedge out_valid=0, busy=0, in_ready=1. Rerun with XLEN=64: DIV latency 65 cycles.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle RV32M/RV64M execute unit (MUL*/DIV*/REM*).
// Multiplies complete a fixed MUL_STAGES cycles after accept. Divides use an
// iterative restoring divider (XLEN steps plus one sign-fix cycle), and
// divide-by-zero and signed-overflow results are produced one cycle after accept.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 abandon any in-flight op
//   in_valid/in_ready     operation handshake; in_ready = idle
//   in_funct3, in_rs1, in_rs2, in_rd   op select, operands, destination tag
//   out_valid/out_ready   result handshake
//   out_result, out_rd    result and returned tag
//   busy                  unit occupied; used as the pipeline stall
module ex_muldiv_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN + MUL_STAGES + 1);
  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      f3_q;
  logic [XLEN-1:0] op_a, op_b;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, spec_res;
  logic            neg_q, neg_r, special_q;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Accept-time divide preparation: magnitudes, result signs, special cases
  logic            div_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_abs, b_abs, spec_val;
  always_comb begin
    div_signed = ~in_funct3[0];
    a_neg      = div_signed & in_rs1[XLEN-1];
    b_neg      = div_signed & in_rs2[XLEN-1];
    a_abs      = a_neg ? (XLEN'(0) - in_rs1) : in_rs1;
    b_abs      = b_neg ? (XLEN'(0) - in_rs2) : in_rs2;
    div_zero   = (in_rs2 == '0);
    div_ovf    = div_signed && (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&in_rs2);
    if (div_zero) spec_val = in_funct3[1] ? in_rs1 : '1;
    else          spec_val = in_funct3[1] ? '0 : in_rs1;
  end

  // Product from latched operands; signedness chosen by funct3[1:0]
  logic                   a_sgn, b_sgn;
  logic signed [XLEN:0]   ma, mb;
  logic [PW-1:0]          prod;
  logic [XLEN-1:0]        mul_res;
  always_comb begin
    a_sgn   = (f3_q == 2'b01) || (f3_q == 2'b10);
    b_sgn   = (f3_q == 2'b01);
    ma      = {a_sgn & op_a[XLEN-1], op_a};
    mb      = {b_sgn & op_b[XLEN-1], op_b};
    prod    = PW'(ma) * PW'(mb);
    mul_res = (f3_q == 2'b00) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
  end

  // One restoring step: shift in next dividend bit, subtract if it fits
  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] diff, q_fix, r_fix;
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    diff    = shifted[XLEN-1:0] - dvs_q;
    q_fix   = neg_q ? (XLEN'(0) - quo_q) : quo_q;
    r_fix   = neg_r ? (XLEN'(0) - rem_q) : rem_q;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      f3_q       <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rd_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      spec_res   <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      special_q  <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            f3_q <= in_funct3[1:0];
            op_a <= in_rs1;
            op_b <= in_rs2;
            rd_q <= in_rd;
            if (!in_funct3[2]) begin
              state <= MUL;
              cnt   <= CW'(MUL_STAGES - 1);
            end else begin
              state     <= DIV;
              cnt       <= CW'(XLEN);
              rem_q     <= '0;
              quo_q     <= a_abs;
              dvs_q     <= b_abs;
              neg_q     <= a_neg ^ b_neg;
              neg_r     <= a_neg;
              special_q <= div_zero | div_ovf;
              spec_res  <= spec_val;
            end
          end
        end
        MUL: begin
          if (cnt == '0) begin
            out_result <= mul_res;
            out_rd     <= rd_q;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DIV: begin
          if (special_q || cnt == '0) begin
            // Special results bypass the iteration; otherwise this is the sign-fix cycle
            if (special_q) out_result <= spec_res;
            else           out_result <= f3_q[1] ? r_fix : q_fix;
            out_rd    <= rd_q;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            rem_q <= fits ? diff : shifted[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], fits};
            cnt   <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: a 32-bit instance for most scenarios and
// a 64-bit instance for the wide divide latency.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n, flush, out_ready;
  logic        in_valid, in_ready, out_valid, busy;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1, in_rs2, out_result;
  logic [4:0]  in_rd, out_rd;

  logic        in_valid64, in_ready64, out_valid64, busy64;
  logic [2:0]  in_funct3_64;
  logic [63:0] in_rs1_64, in_rs2_64, out_result64;
  logic [4:0]  in_rd64, out_rd64;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .MUL_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .busy(busy)
  );

  ex_muldiv_unit #(.XLEN(64), .MUL_STAGES(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_funct3(in_funct3_64),
    .in_rs1(in_rs1_64), .in_rs2(in_rs2_64), .in_rd(in_rd64),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_result(out_result64), .out_rd(out_rd64), .busy(busy64)
  );

  // Offer one op, measure accept-to-out_valid latency, then complete the handshake
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output logic [31:0] res,
                        output logic [4:0] rd_o);
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_rd = rd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res  = out_result;
    rd_o = out_rd;
    @(posedge clk); #1;
  endtask

  task automatic run_op64(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                          output int lat, output logic [63:0] res);
    @(negedge clk);
    in_valid64 = 1'b1; in_funct3_64 = f3; in_rs1_64 = a; in_rs2_64 = b; in_rd64 = 5'd17;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    lat = 0;
    while (!out_valid64 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_result64;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_result !== 32'h0) begin failures++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
    checks++; if (out_rd !== 5'd0) begin failures++; $display("FAIL reset_out_rd got=%0d exp=0", out_rd); end
    checks++; if (out_valid64 !== 1'b0 || busy64 !== 1'b0) begin failures++; $display("FAIL reset_64 got valid=%b busy=%b exp 0/0", out_valid64, busy64); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    int lat, bc;
    logic [31:0] res;
    logic [4:0] rdo;
    // MUL 7 x -3 with busy-duration tracking
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = 3'b000; in_rs1 = 32'h7; in_rs2 = 32'hFFFF_FFFD; in_rd = 5'd11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    bc = 0; lat = 0;
    while (busy && bc < 20) begin
      if (out_valid && lat == 0) begin lat = bc; res = out_result; rdo = out_rd; end
      bc++;
      @(posedge clk); #1;
    end
    checks++; if (lat !== 2) begin failures++; $display("FAIL mul_latency got=%0d exp=2", lat); end
    checks++; if (res !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_result got=%h exp=ffffffeb", res); end
    checks++; if (rdo !== 5'd11) begin failures++; $display("FAIL mul_rd got=%0d exp=11", rdo); end
    checks++; if (bc !== 3) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=3", bc); end
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, lat, res, rdo);
    checks++; if (res !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulhu got=%h exp=fffffffe", res); end
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, lat, res, rdo);
    checks++; if (res !== 32'h0) begin failures++; $display("FAIL mulh got=%h exp=00000000", res); end
    run_op(3'b010, 32'hFFFF_FFFF, 32'h2, 5'd3, lat, res, rdo);
    checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulhsu got=%h exp=ffffffff", res); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL mulhsu_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_div();
    int lat;
    logic [31:0] res;
    logic [4:0] rdo;
    run_op(3'b100, 32'hFFFF_FFEC, 32'h6, 5'd7, lat, res, rdo);
    checks++; if (res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg got=%h exp=fffffffd", res); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL div_latency got=%0d exp=33", lat); end
    checks++; if (rdo !== 5'd7) begin failures++; $display("FAIL div_rd got=%0d exp=7", rdo); end
    run_op(3'b110, 32'hFFFF_FFEC, 32'h6, 5'd8, lat, res, rdo);
    checks++; if (res !== 32'hFFFF_FFFE) begin failures++; $display("FAIL rem_neg got=%h exp=fffffffe", res); end
    run_op(3'b101, 32'd100, 32'd7, 5'd9, lat, res, rdo);
    checks++; if (res !== 32'd14) begin failures++; $display("FAIL divu got=%0d exp=14", res); end
    run_op(3'b111, 32'd100, 32'd7, 5'd10, lat, res, rdo);
    checks++; if (res !== 32'd2) begin failures++; $display("FAIL remu got=%0d exp=2", res); end
    // Unsigned divide of the signed-overflow pattern goes through the normal path
    run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, lat, res, rdo);
    checks++; if (res !== 32'h0 || lat !== 33) begin failures++; $display("FAIL divu_no_ovf got=%h lat=%0d exp=00000000 lat=33", res, lat); end
  endtask

  task automatic test_special();
    int lat;
    logic [31:0] res;
    logic [4:0] rdo;
    run_op(3'b100, 32'd5, 32'd0, 5'd4, lat, res, rdo);
    checks++; if (res !== 32'hFFFF_FFFF || lat !== 1) begin failures++; $display("FAIL div_by_zero got=%h lat=%0d exp=ffffffff lat=1", res, lat); end
    run_op(3'b110, 32'd5, 32'd0, 5'd4, lat, res, rdo);
    checks++; if (res !== 32'd5 || lat !== 1) begin failures++; $display("FAIL rem_by_zero got=%h lat=%0d exp=00000005 lat=1", res, lat); end
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, lat, res, rdo);
    checks++; if (res !== 32'h8000_0000 || lat !== 1) begin failures++; $display("FAIL div_ovf got=%h lat=%0d exp=80000000 lat=1", res, lat); end
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, lat, res, rdo);
    checks++; if (res !== 32'h0 || lat !== 1) begin failures++; $display("FAIL rem_ovf got=%h lat=%0d exp=00000000 lat=1", res, lat); end
    run_op(3'b111, 32'd9, 32'd0, 5'd4, lat, res, rdo);
    checks++; if (res !== 32'd9 || lat !== 1) begin failures++; $display("FAIL remu_by_zero got=%h lat=%0d exp=00000009 lat=1", res, lat); end
  endtask

  task automatic test_backpressure();
    int w;
    logic [31:0] held;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = 3'b000; in_rs1 = 32'd6; in_rs2 = 32'd7; in_rd = 5'd9;
    @(posedge clk); #1;
    in_funct3 = 3'b001; in_rs1 = 32'd1; in_rs2 = 32'd1; in_rd = 5'd30;
    w = 0;
    while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
    held = out_result;
    checks++; if (held !== 32'd42) begin failures++; $display("FAIL bp_result got=%0d exp=42", held); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'd42 || in_ready !== 1'b0 || out_rd !== 5'd9) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got valid=%b res=%0d ready=%b rd=%0d exp 1/42/0/9", i, out_valid, out_result, in_ready, out_rd);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got valid=%b ready=%b exp 0/1", out_valid, in_ready); end
  endtask

  task automatic test_flush();
    int lat;
    int seen;
    logic [31:0] res;
    logic [4:0] rdo;
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = 3'b101; in_rs1 = 32'd1000; in_rs2 = 32'd3; in_rd = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_div got busy=%b valid=%b ready=%b exp 0/0/1", busy, out_valid, in_ready); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL flush_no_result got=%0d active cycles exp=0", seen); end
    // Flush wins over a simultaneous accept
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; in_funct3 = 3'b000; in_rs1 = 32'd2; in_rs2 = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_vs_accept got busy=%b exp=0", busy); end
    run_op(3'b000, 32'd3, 32'd4, 5'd20, lat, res, rdo);
    checks++; if (res !== 32'd12 || lat !== 2) begin failures++; $display("FAIL flush_reaccept got=%0d lat=%0d exp=12 lat=2", res, lat); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] res;
    logic [4:0] rdo;
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = 3'b100; in_rs1 = 32'd77; in_rs2 = 32'd5; in_rd = 5'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL reset_mid got valid=%b busy=%b ready=%b exp 0/0/1", out_valid, busy, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b100, 32'd77, 32'd5, 5'd6, lat, res, rdo);
    checks++; if (res !== 32'd15 || lat !== 33) begin failures++; $display("FAIL reset_rerun got=%0d lat=%0d exp=15 lat=33", res, lat); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] res;
    logic [4:0] rdo;
    run_op(3'b000, 32'd100, 32'd200, 5'd21, lat, res, rdo);
    checks++; if (res !== 32'd20000 || rdo !== 5'd21) begin failures++; $display("FAIL b2b_first got=%0d rd=%0d exp=20000 rd=21", res, rdo); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
    run_op(3'b110, 32'd100, 32'hFFFF_FFF9, 5'd22, lat, res, rdo);
    checks++; if (res !== 32'd2 || rdo !== 5'd22 || lat !== 33) begin failures++; $display("FAIL b2b_second got=%0d rd=%0d lat=%0d exp=2 rd=22 lat=33", res, rdo, lat); end
  endtask

  task automatic test_div64();
    int lat;
    logic [63:0] res;
    run_op64(3'b100, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, lat, res);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL div64 got=%h exp=fffffffffffffffd", res); end
    checks++; if (lat !== 65) begin failures++; $display("FAIL div64_latency got=%0d exp=65", lat); end
    run_op64(3'b101, 64'h8000_0000_0000_0000, 64'd3, lat, res);
    checks++; if (res !== 64'h2AAA_AAAA_AAAA_AAAA) begin failures++; $display("FAIL divu64 got=%h exp=2aaaaaaaaaaaaaaa", res); end
    run_op64(3'b111, 64'h8000_0000_0000_0000, 64'd3, lat, res);
    checks++; if (res !== 64'd2) begin failures++; $display("FAIL remu64 got=%h exp=2", res); end
    run_op64(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, lat, res);
    checks++; if (res !== 64'd1 || lat !== 2) begin failures++; $display("FAIL mulhu64 got=%h lat=%0d exp=1 lat=2", res, lat); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_funct3 = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_valid64 = 1'b0; in_funct3_64 = '0; in_rs1_64 = '0; in_rs2_64 = '0; in_rd64 = '0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_div64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
